xy_frame_capture: RTL and testbench

- Receive-side counterpart of the scope XY multiplexer.
- Accepts the time-multiplexed 8-bit x/y sample stream in slot order: ball (slot 0), paddle (slot 1), border (slot 2). A frame_sync marker flags slot 0.
- Locks to the slot sequence, de-interleaves the stream into per-object coordinate registers and commits each complete frame atomically.
- Used for the scope-image mirror path and as a loopback checker in bench and hardware.

---
 rtl/xy_frame_capture_if.sv | 13 +
 rtl/xy_frame_capture.sv | 208 ++++++++++++++++++++
 tb/tb_xy_frame_capture.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_frame_capture_if.sv
// Multiplexed x/y sample stream carried from the scope XY multiplexer to the
// frame capture block.
interface xy_frame_capture_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sample_en;
  logic         frame_sync;

  modport master (output x, y, sample_en, frame_sync);
  modport slave  (input  x, y, sample_en, frame_sync);
endinterface

// File: rtl/xy_frame_capture.sv
// Locks to the ball/paddle/border slot sequence and commits whole frames atomically.
// Optional macro XY_MOTION_FLAG_EN enables per-object change flags on 'moved'.
module xy_frame_capture #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xy_frame_capture_if.slave    s,
  output logic [W-1:0]         x_b,
  output logic [W-1:0]         y_b,
  output logic [W-1:0]         x_p,
  output logic [W-1:0]         y_p,
  output logic [W-1:0]         x_border,
  output logic [W-1:0]         y_border,
  output logic                 frame_valid,
  output logic                 locked,
  output logic                 sync_err,
  output logic [7:0]           err_cnt,
  output logic [2:0]           moved
);

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} state_e;

  state_e       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [3:0]   good_q, good_d;
  logic [3:0]   good_inc;
  logic [W-1:0] sx0_q, sx0_d, sy0_q, sy0_d, sx1_q, sx1_d, sy1_q, sy1_d;
  logic [W-1:0] xb_q, xb_d, yb_q, yb_d, xp_q, xp_d, yp_q, yp_d;
  logic [W-1:0] xd_q, xd_d, yd_q, yd_d;
  logic         fv_q, fv_d, se_q, se_d, locked_q, locked_d;
  logic [7:0]   err_cnt_q, err_cnt_d;
  logic         commit, err;

  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    good_d    = good_q;
    sx0_d     = sx0_q;
    sy0_d     = sy0_q;
    sx1_d     = sx1_q;
    sy1_d     = sy1_q;
    xb_d      = xb_q;
    yb_d      = yb_q;
    xp_d      = xp_q;
    yp_d      = yp_q;
    xd_d      = xd_q;
    yd_d      = yd_q;
    err_cnt_d = err_cnt_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;

    if (s.sample_en) begin
      if (slot_q == 2'd3) begin
        state_d = HUNT;
        slot_d  = 2'd0;
      end else begin
        case (state_q)
          HUNT: begin
            if (s.frame_sync) begin
              sx0_d   = s.x;
              sy0_d   = s.y;
              slot_d  = 2'd1;
              good_d  = '0;
              state_d = LOCKING;
            end
          end
          default: begin
            if (slot_q == 2'd0 && !s.frame_sync) begin
              err     = 1'b1;
              state_d = HUNT;
              slot_d  = 2'd0;
            end else if (slot_q != 2'd0 && s.frame_sync) begin
              // Misplaced sync restarts the frame with this sample as slot 0.
              err     = 1'b1;
              sx0_d   = s.x;
              sy0_d   = s.y;
              slot_d  = 2'd1;
              good_d  = '0;
              state_d = LOCKING;
            end else begin
              case (slot_q)
                2'd0: begin
                  sx0_d  = s.x;
                  sy0_d  = s.y;
                  slot_d = 2'd1;
                end
                2'd1: begin
                  sx1_d  = s.x;
                  sy1_d  = s.y;
                  slot_d = 2'd2;
                end
                default: begin
                  slot_d = 2'd0;
                  if (state_q == LOCKING) begin
                    good_d = good_inc;
                    if (good_inc == 4'(LOCK_FRAMES)) begin
                      state_d = LOCKED;
                      commit  = 1'b1;
                    end
                  end else begin
                    commit = 1'b1;
                  end
                end
              endcase
            end
          end
        endcase
      end
    end

    if (err) begin
      se_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    if (commit) begin
      xb_d = sx0_q;
      yb_d = sy0_q;
      xp_d = sx1_q;
      yp_d = sy1_q;
      xd_d = s.x;
      yd_d = s.y;
      fv_d = 1'b1;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      slot_q    <= '0;
      good_q    <= '0;
      sx0_q     <= '0;
      sy0_q     <= '0;
      sx1_q     <= '0;
      sy1_q     <= '0;
      xb_q      <= '0;
      yb_q      <= '0;
      xp_q      <= '0;
      yp_q      <= '0;
      xd_q      <= '0;
      yd_q      <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      good_q    <= good_d;
      sx0_q     <= sx0_d;
      sy0_q     <= sy0_d;
      sx1_q     <= sx1_d;
      sy1_q     <= sy1_d;
      xb_q      <= xb_d;
      yb_q      <= yb_d;
      xp_q      <= xp_d;
      yp_q      <= yp_d;
      xd_q      <= xd_d;
      yd_q      <= yd_d;
      fv_q      <= fv_d;
      se_q      <= se_d;
      locked_q  <= locked_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef XY_MOTION_FLAG_EN
  logic [2:0] moved_q, moved_d;

  always_comb begin
    moved_d = moved_q;
    if (commit) begin
      moved_d[0] = (sx0_q != xb_q) || (sy0_q != yb_q);
      moved_d[1] = (sx1_q != xp_q) || (sy1_q != yp_q);
      moved_d[2] = (s.x   != xd_q) || (s.y   != yd_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) moved_q <= '0;
    else        moved_q <= moved_d;
  end

  assign moved = moved_q;
`else
  assign moved = '0;
`endif

  assign x_b         = xb_q;
  assign y_b         = yb_q;
  assign x_p         = xp_q;
  assign y_p         = yp_q;
  assign x_border    = xd_q;
  assign y_border    = yd_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = locked_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_xy_frame_capture.sv
// Directed + randomized bench for xy_frame_capture with a frame-level reference model.
module tb_xy_frame_capture;

  localparam int unsigned LOCKN = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] x_b, y_b, x_p, y_p, x_border, y_border;
  logic       frame_valid, locked, sync_err;
  logic [7:0] err_cnt;
  logic [2:0] moved;

  xy_frame_capture_if #(.W(8)) bus ();

  xy_frame_capture #(.LOCK_FRAMES(LOCKN), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .x_b(x_b), .y_b(y_b), .x_p(x_p), .y_p(y_p),
    .x_border(x_border), .y_border(y_border),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
    .err_cnt(err_cnt), .moved(moved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame under collection as a queue of {x,y} pairs.
  logic [15:0] m_frame[$];
  bit          m_synced;
  bit          m_locked;
  int          m_good;
  int          m_err;
  int          m_x[3];
  int          m_y[3];
  int          m_moved;
  int          exp_fv, exp_se;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".frame_valid"}, int'(frame_valid), exp_fv);
    check({tag, ".sync_err"},    int'(sync_err),    exp_se);
    check({tag, ".locked"},      int'(locked),      int'(m_locked));
    check({tag, ".err_cnt"},     int'(err_cnt),     m_err);
    check({tag, ".x_b"},         int'(x_b),         m_x[0]);
    check({tag, ".y_b"},         int'(y_b),         m_y[0]);
    check({tag, ".x_p"},         int'(x_p),         m_x[1]);
    check({tag, ".y_p"},         int'(y_p),         m_y[1]);
    check({tag, ".x_border"},    int'(x_border),    m_x[2]);
    check({tag, ".y_border"},    int'(y_border),    m_y[2]);
    check({tag, ".moved"},       int'(moved),       m_moved);
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_synced = 0;
    m_locked = 0;
    m_good   = 0;
    m_err    = 0;
    m_moved  = 0;
    exp_fv   = 0;
    exp_se   = 0;
    for (int i = 0; i < 3; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
  endtask

  task automatic model_error();
    exp_se = 1;
    if (m_err < 255) m_err++;
    m_locked = 0;
    m_good   = 0;
  endtask

  task automatic model_sample(input int xv, input int yv, input bit sy);
    int chg;
    exp_fv = 0;
    exp_se = 0;
    if (!m_synced) begin
      if (sy) begin
        m_frame.delete();
        m_frame.push_back({xv[7:0], yv[7:0]});
        m_synced = 1;
        m_good   = 0;
      end
    end else if (m_frame.size() == 0 && !sy) begin
      model_error();
      m_synced = 0;
    end else if (m_frame.size() != 0 && sy) begin
      model_error();
      m_frame.delete();
      m_frame.push_back({xv[7:0], yv[7:0]});
    end else begin
      m_frame.push_back({xv[7:0], yv[7:0]});
      if (m_frame.size() == 3) begin
        if (!m_locked) begin
          m_good++;
          if (m_good >= LOCKN) m_locked = 1;
        end
        if (m_locked) begin
          chg = 0;
          for (int i = 0; i < 3; i++) begin
            if (int'(m_frame[i][15:8]) != m_x[i] || int'(m_frame[i][7:0]) != m_y[i])
              chg |= (1 << i);
            m_x[i] = int'(m_frame[i][15:8]);
            m_y[i] = int'(m_frame[i][7:0]);
          end
`ifdef XY_MOTION_FLAG_EN
          m_moved = chg;
`else
          m_moved = 0;
`endif
          exp_fv = 1;
        end
        m_frame.delete();
      end
    end
  endtask

  task automatic send(input int xv, input int yv, input bit sy, input string tag);
    @(negedge clk);
    bus.x          = xv[7:0];
    bus.y          = yv[7:0];
    bus.frame_sync = sy;
    bus.sample_en  = 1'b1;
    model_sample(xv, yv, sy);
    @(posedge clk);
    #1;
    bus.sample_en  = 1'b0;
    bus.frame_sync = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_fv = 0;
      exp_se = 0;
      check_all(tag);
    end
  endtask

  task automatic std_frame(input string tag);
    send(10, 20, 1, tag);
    send(30, 40, 0, tag);
    send(50, 60, 0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int phase;
    bit sy;
    rst_n          = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.sample_en  = 1'b0;
    bus.frame_sync = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: frame 1 builds lock, frame 2 commits.
    std_frame("frame1");
    check("frame1_no_commit_locked", int'(locked), 0);
    std_frame("frame2");
    check("frame2_x_b", int'(x_b), 10);
    check("frame2_y_border", int'(y_border), 60);
    check("frame2_fv", int'(frame_valid), 1);
    check("frame2_locked", int'(locked), 1);
    idle(1, "frame2_fv_drop");
    std_frame("frame3");

    // Locked stream with sample_en gaps.
    for (int f = 0; f < 4; f++) begin
      send(10, 20, 1, "gap");
      idle($urandom_range(0, 3), "gap_idle");
      send(30, 40, 0, "gap");
      idle($urandom_range(0, 3), "gap_idle");
      send(50, 60, 0, "gap");
      idle($urandom_range(0, 3), "gap_idle");
    end

    // Sync on slot 1: error, restart, relock.
    send(10, 20, 1, "s1sync");
    send(11, 12, 1, "s1sync_err");
    check("s1sync_errcnt", int'(err_cnt), 1);
    check("s1sync_locked", int'(locked), 0);
    check("s1sync_hold_x_p", int'(x_p), 30);
    send(30, 40, 0, "relock_a");
    send(50, 60, 0, "relock_a");
    std_frame("relock_b");
    check("relock_locked", int'(locked), 1);

    // Slot 0 without sync: back to hunting, stray samples ignored.
    send(1, 2, 0, "nosync_err");
    check("nosync_errcnt", int'(err_cnt), 2);
    send(3, 4, 0, "hunt_ignore");
    send(5, 6, 0, "hunt_ignore");
    send(7, 8, 0, "hunt_ignore");
    std_frame("hunt_relock1");
    std_frame("hunt_relock2");

    // Paddle-only change.
    send(10, 20, 1, "paddle");
    send(31, 40, 0, "paddle");
    send(50, 60, 0, "paddle");
`ifdef XY_MOTION_FLAG_EN
    check("paddle_moved", int'(moved), 2);
`endif
    send(10, 20, 1, "paddle_same");
    send(31, 40, 0, "paddle_same");
    send(50, 60, 0, "paddle_same");
    check("paddle_same_moved", int'(moved), 0);

    // Randomized stream with occasional misplaced or missing syncs.
    phase = 0;
    for (int i = 0; i < 400; i++) begin
      sy = (phase == 0);
      if ($urandom_range(0, 15) == 0) sy = ~sy;
      send($urandom_range(0, 255), $urandom_range(0, 255), sy, "rand");
      phase = (phase + 1) % 3;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), "rand_idle");
    end

    // Mid-frame reset discards the partial frame.
    std_frame("prereset1");
    std_frame("prereset2");
    send(1, 2, 1, "prereset_s0");
    @(negedge clk);
    bus.x         = 8'd77;
    bus.y         = 8'd88;
    bus.sample_en = 1'b1;
    rst_n         = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    bus.sample_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(30, 40, 0, "postreset");
    send(50, 60, 0, "postreset");
    check("postreset_no_commit", int'(x_border), 0);

    // Error counter saturation.
    send(1, 1, 1, "sat_start");
    for (int i = 0; i < 260; i++) send(i % 256, 3, 1, "sat");
    check("sat_errcnt", int'(err_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
